// File: rtl/modbus_defs_pkg.sv
`default_nettype none
// modbus_defs_pkg: Modbus RTU constants and framer state encoding shared by the
// transmit framer and the receive-side CRC check.
package modbus_defs_pkg;

  localparam logic [7:0] FC_READ_HOLDING = 8'h03;
  localparam logic [7:0] FC_READ_INPUT   = 8'h04;
  localparam logic [7:0] FC_WRITE_SINGLE = 8'h06;

  localparam logic [7:0] EXC_ILLEGAL_FUNCTION     = 8'h01;
  localparam logic [7:0] EXC_ILLEGAL_DATA_ADDRESS = 8'h02;
  localparam logic [7:0] EXC_ILLEGAL_DATA_VALUE   = 8'h03;
  localparam logic [7:0] EXC_SLAVE_DEVICE_FAILURE = 8'h04;

  localparam logic [7:0] EXC_FLAG        = 8'h80;
  localparam logic [7:0] READ_BYTE_COUNT = 8'h02;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUILD = 3'd1,
    ST_CRC   = 3'd2,
    ST_SEND  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_GUARD = 3'd5
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/crc16_modbus_byte.sv
`default_nettype none
// crc16_modbus_byte: one-byte CRC16/Modbus update (reflected 0xA001), purely
// combinational so it can sit in any one-byte-per-cycle datapath.
module crc16_modbus_byte
  import modbus_defs_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  logic [15:0] acc;

  always_comb begin
    acc = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      acc = acc[0] ? ((acc >> 1) ^ CRC_POLY) : (acc >> 1);
    end
    crc_out = acc;
  end

endmodule
`default_nettype wire

// File: rtl/modbus_frame_tx.sv
`default_nettype none
// modbus_frame_tx: Modbus RTU slave reply framer; builds ADDR/func/payload/CRC and
// streams it byte-by-byte to uart_byte_tx, then holds a 3.5-character silent gap.
module modbus_frame_tx
  import modbus_defs_pkg::*;
#(
  parameter logic [7:0] ADDR      = 8'h02,
  parameter int         CLK_FREQ  = 50000000,
  parameter int         BAUD_RATE = 115200
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        tx_req,
  input  logic [7:0]  tx_func_code,
  input  logic [15:0] tx_addr,
  input  logic [15:0] tx_data,
  input  logic        tx_exception,
  input  logic        uart_tx_done,
  output logic        uart_tx_start,
  output logic [7:0]  uart_tx_data,
  output logic        busy,
  output logic        tx_frame_done,
  output logic        tx_error
);

  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int T35_CYC = BIT_CYC * 385 / 10;
  localparam int WD_CYC  = 16 * BIT_CYC;
  localparam int GW      = $clog2(T35_CYC + 1);
  localparam int WW      = $clog2(WD_CYC + 1);

  tx_state_t state, state_next;

  logic [7:0]    func_q;
  logic [15:0]   addr_q;
  logic [15:0]   data_q;
  logic          exc_q;
  logic [7:0]    frame_buf [8];
  logic [3:0]    len;
  logic [3:0]    idx;
  logic [15:0]   crc;
  logic [15:0]   crc_next;
  logic [GW-1:0] guard_cnt;
  logic [WW-1:0] wd_cnt;
  logic          busy_q;
  logic          frame_done_q;
  logic          error_q;

  logic [3:0] len_m1;
  logic [3:0] len_m2;
  logic       crc_last;
  logic       byte_last;
  logic       wd_expired;
  logic       guard_expired;
  logic       supported;
  logic       build_exc;
  logic [7:0] exc_code;

  assign len_m1        = len - 4'd1;
  assign len_m2        = len - 4'd2;
  assign crc_last      = (idx == len_m2);
  assign byte_last     = (idx == len_m1);
  assign wd_expired    = (wd_cnt == WW'(WD_CYC - 1));
  assign guard_expired = (guard_cnt == GW'(T35_CYC - 1));

  // An explicit exception request wins; unknown functions fall back to code 0x01.
  assign supported = (func_q == FC_READ_HOLDING) || (func_q == FC_READ_INPUT) ||
                     (func_q == FC_WRITE_SINGLE);
  assign build_exc = exc_q || !supported;
  assign exc_code  = exc_q ? data_q[7:0] : EXC_ILLEGAL_FUNCTION;

  crc16_modbus_byte u_crc (
    .crc_in  (crc),
    .byte_in (frame_buf[idx[2:0]]),
    .crc_out (crc_next)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    uart_tx_start = 1'b0;
    uart_tx_data  = 8'h00;
    case (state)
      ST_IDLE: begin
        if (tx_req) state_next = ST_BUILD;
      end
      ST_BUILD: begin
        state_next = ST_CRC;
      end
      ST_CRC: begin
        if (crc_last) state_next = ST_SEND;
      end
      ST_SEND: begin
        uart_tx_start = 1'b1;
        uart_tx_data  = frame_buf[idx[2:0]];
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        uart_tx_data = frame_buf[idx[2:0]];
        if (uart_tx_done) begin
          state_next = byte_last ? ST_GUARD : ST_SEND;
        end else if (wd_expired) begin
          state_next = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_expired) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      func_q       <= 8'h00;
      addr_q       <= 16'h0000;
      data_q       <= 16'h0000;
      exc_q        <= 1'b0;
      len          <= 4'd0;
      idx          <= 4'd0;
      crc          <= 16'h0000;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      for (int i = 0; i < 8; i++) frame_buf[i] <= 8'h00;
    end else begin
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_req) begin
            func_q <= tx_func_code;
            addr_q <= tx_addr;
            data_q <= tx_data;
            exc_q  <= tx_exception;
            busy_q <= 1'b1;
          end
        end
        ST_BUILD: begin
          for (int i = 0; i < 8; i++) frame_buf[i] <= 8'h00;
          frame_buf[0] <= ADDR;
          if (build_exc) begin
            frame_buf[1] <= func_q | EXC_FLAG;
            frame_buf[2] <= exc_code;
            len          <= 4'd5;
          end else if (func_q == FC_WRITE_SINGLE) begin
            frame_buf[1] <= func_q;
            frame_buf[2] <= addr_q[15:8];
            frame_buf[3] <= addr_q[7:0];
            frame_buf[4] <= data_q[15:8];
            frame_buf[5] <= data_q[7:0];
            len          <= 4'd8;
          end else begin
            frame_buf[1] <= func_q;
            frame_buf[2] <= READ_BYTE_COUNT;
            frame_buf[3] <= data_q[15:8];
            frame_buf[4] <= data_q[7:0];
            len          <= 4'd7;
          end
          idx <= 4'd0;
          crc <= CRC_INIT;
        end
        ST_CRC: begin
          // Payload is folded in one byte per cycle; the final cycle appends CRC lo/hi.
          if (crc_last) begin
            frame_buf[len_m2[2:0]] <= crc[7:0];
            frame_buf[len_m1[2:0]] <= crc[15:8];
            idx                    <= 4'd0;
          end else begin
            crc <= crc_next;
            idx <= idx + 4'd1;
          end
        end
        ST_WAIT: begin
          if (uart_tx_done) begin
            idx <= idx + 4'd1;
            if (byte_last) frame_done_q <= 1'b1;
          end else if (wd_expired) begin
            error_q <= 1'b1;
          end
        end
        ST_GUARD: begin
          if (guard_expired) busy_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Watchdog runs from the start pulse of each byte; guard counter only in GUARD.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      guard_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      guard_cnt <= (state == ST_GUARD) ? guard_cnt + GW'(1) : '0;
      if ((state == ST_SEND || state == ST_WAIT) && state_next != ST_SEND) begin
        wd_cnt <= wd_cnt + WW'(1);
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  assign busy          = busy_q;
  assign tx_frame_done = frame_done_q;
  assign tx_error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_modbus_frame_tx.sv
`default_nettype none
// tb_modbus_frame_tx: directed frames against hand-computed Modbus replies, with a
// behavioural UART that captures bytes on start pulses and answers with tx_done.
module tb_modbus_frame_tx;

  localparam int T35   = 16709;
  localparam int WD    = 6944;
  localparam int DLY   = 20;
  localparam int LIMIT = 30000;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tx_req = 1'b0;
  logic [7:0]  tx_func_code = 8'h00;
  logic [15:0] tx_addr = 16'h0000;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_exception = 1'b0;
  logic        uart_tx_done = 1'b0;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        busy;
  logic        tx_frame_done;
  logic        tx_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rx_b  [16];
  logic [7:0] exp_b [16];
  int rx_n, exp_n;
  int first_start, done_cnt, err_cnt, busy_fall, err_at, fd_at;

  always #10 sys_clk = ~sys_clk;

  modbus_frame_tx #(
    .ADDR      (8'h01),
    .CLK_FREQ  (50000000),
    .BAUD_RATE (115200)
  ) dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .tx_req        (tx_req),
    .tx_func_code  (tx_func_code),
    .tx_addr       (tx_addr),
    .tx_data       (tx_data),
    .tx_exception  (tx_exception),
    .uart_tx_done  (uart_tx_done),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .busy          (busy),
    .tx_frame_done (tx_frame_done),
    .tx_error      (tx_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, exp_b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic load_exp(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_b[i] = v[8*(n-1-i) +: 8];
    exp_n = n;
  endtask

  task automatic add_crc();
    logic [15:0] c;
    c = crc_model(exp_n);
    exp_b[exp_n]     = c[7:0];
    exp_b[exp_n + 1] = c[15:8];
    exp_n += 2;
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, 32'(rx_n), 32'(exp_n));
    for (int i = 0; i < exp_n; i++)
      check($sformatf("%s_b%0d", tag, i), {24'h0, rx_b[i]}, {24'h0, exp_b[i]});
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tx_req = 1'b0;
    uart_tx_done = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic idle_check(input string tag, input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (uart_tx_start || busy) act++;
    end
    check(tag, 32'(act), 0);
  endtask

  // cut: 0 run until busy falls, 1 stop at tx_frame_done, 2 stop at third start pulse.
  task automatic run_frame(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                           input logic e, input bit uart_on, input int cut,
                           input int req_mid, input bit req_at_expiry);
    int pend;
    bit timed_out;
    for (int i = 0; i < 16; i++) rx_b[i] = 8'h00;
    rx_n = 0; first_start = -1; done_cnt = 0; err_cnt = 0;
    busy_fall = -1; err_at = -1; fd_at = -1; pend = 0; timed_out = 1'b1;
    tx_func_code = f; tx_addr = a; tx_data = d; tx_exception = e;
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
    for (int t = 1; t <= LIMIT; t++) begin
      step();
      if (uart_tx_start) begin
        if (first_start < 0) first_start = t;
        if (rx_n < 16) rx_b[rx_n] = uart_tx_data;
        rx_n++;
        pend = DLY;
      end
      if (tx_frame_done) begin done_cnt++; fd_at = t; end
      if (tx_error) begin err_cnt++; err_at = t; end
      tx_req = (t == req_mid) || (req_at_expiry && fd_at >= 0 && t == fd_at + T35 - 1);
      uart_tx_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && uart_on) uart_tx_done = 1'b1;
      end
      if ((cut == 1 && tx_frame_done) || (cut == 2 && rx_n == 3) || !busy) begin
        if (!busy) busy_fall = t;
        timed_out = 1'b0;
        break;
      end
    end
    tx_req = 1'b0;
    uart_tx_done = 1'b0;
    check("frame_timeout", 32'(timed_out), 0);
  endtask

  initial begin
    step();
    step();
    check("rst_start", 32'(uart_tx_start), 0);
    check("rst_data", 32'(uart_tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(tx_frame_done), 0);
    check("rst_error", 32'(tx_error), 0);
    reset_n = 1'b1;
    step();

    load_exp(64'h0106_0001_0003_980B, 8);
    run_frame(8'h06, 16'h0001, 16'h0003, 1'b0, 1'b1, 1, -1, 1'b0);
    compare_frame("echo");
    check("echo_first_start", 32'(first_start), 8);
    check("echo_done_cnt", 32'(done_cnt), 1);
    check("echo_err_cnt", 32'(err_cnt), 0);
    apply_reset();

    load_exp(64'h01_8302_C0F1, 5);
    run_frame(8'h03, 16'h0000, 16'h0002, 1'b1, 1'b1, 1, -1, 1'b0);
    compare_frame("exc");
    check("exc_first_start", 32'(first_start), 5);
    apply_reset();

    load_exp(64'h01_0302_1234, 5);
    add_crc();
    run_frame(8'h03, 16'h0000, 16'h1234, 1'b0, 1'b1, 1, -1, 1'b0);
    compare_frame("read");
    check("read_first_start", 32'(first_start), 7);
    apply_reset();

    // Full guard interval, with extra requests mid-frame and on the expiry cycle.
    load_exp(64'h01_9001, 3);
    add_crc();
    run_frame(8'h10, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 30, 1'b1);
    compare_frame("unsup");
    check("unsup_first_start", 32'(first_start), 5);
    check("unsup_done_cnt", 32'(done_cnt), 1);
    check("unsup_guard", 32'(busy_fall - fd_at), T35);
    idle_check("unsup_req_ignored", 40);

    run_frame(8'h03, 16'h0000, 16'h0001, 1'b0, 1'b0, 0, -1, 1'b0);
    check("wd_err_cnt", 32'(err_cnt), 1);
    check("wd_done_cnt", 32'(done_cnt), 0);
    check("wd_bytes", 32'(rx_n), 1);
    check("wd_latency", 32'(err_at - first_start), WD);
    check("wd_guard", 32'(busy_fall - err_at), T35);

    run_frame(8'h03, 16'h0000, 16'h5555, 1'b0, 1'b1, 2, -1, 1'b0);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    check("rstmid_start", 32'(uart_tx_start), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_done", 32'(tx_frame_done), 0);
    step();
    reset_n = 1'b1;
    idle_check("rstmid_idle", 40);

    load_exp(64'h01_0402_ABCD, 5);
    add_crc();
    run_frame(8'h04, 16'h0000, 16'hABCD, 1'b0, 1'b1, 1, -1, 1'b0);
    compare_frame("clean");
    check("clean_first_start", 32'(first_start), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
